// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N-to-1 word mux with a registered output, valid/ready handshake and
// fixed or round-robin channel selection. Define MUX_SEL_ERR_EN to add the sticky sel_err flag.
module mux_nto1_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                      sel_err
`endif
);

  logic             loadEn;
  logic             transfer;
  logic             fixedValid;
  logic             anyHi;
  logic             anyLo;
  logic             rrFound;
  logic             grantValid;
  logic [SEL_W-1:0] hiIdx;
  logic [SEL_W-1:0] loIdx;
  logic [SEL_W-1:0] rrIdx;
  logic [SEL_W-1:0] grantIdx;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptrNext;
  logic [WIDTH-1:0] grantWord;

  assign loadEn   = !out_valid || out_ready;
  assign transfer = !res && loadEn && grantValid;

  // Round-robin: lowest valid channel at or above ptr, else lowest valid channel overall.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fixedValid = 1'b0;
    anyHi      = 1'b0;
    anyLo      = 1'b0;
    hiIdx      = '0;
    loIdx      = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (sel == SEL_W'(k)) fixedValid = in_valid[k];
      if (in_valid[k]) begin
        anyLo = 1'b1;
        loIdx = SEL_W'(k);
        if (SEL_W'(k) >= ptr) begin
          anyHi = 1'b1;
          hiIdx = SEL_W'(k);
        end
      end
    end
    rrFound = anyHi || anyLo;
    rrIdx   = anyHi ? hiIdx : loIdx;
  end

  assign grantValid = mode ? rrFound : fixedValid;
  assign grantIdx   = mode ? rrIdx : sel;
  assign ptrNext    = (32'(grantIdx) == 32'(CHANNELS - 1)) ? '0 : grantIdx + 1'b1;

  // An out-of-range sel matches no channel, so it yields no grant and no word.
  always_comb begin
    grantWord = '0;
    in_ready  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grantIdx == SEL_W'(k)) begin
        grantWord   = in_bus[k*WIDTH +: WIDTH];
        in_ready[k] = !res && loadEn && grantValid;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (loadEn) begin
      if (transfer) begin
        out       <= grantWord;
        out_ch    <= grantIdx;
        out_valid <= 1'b1;
        if (mode) ptr <= ptrNext;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic selInRange;
  assign selInRange = 32'(sel) < 32'(CHANNELS);

  always_ff @(posedge clk) begin
    if (res) begin
      sel_err <= 1'b0;
    end else if (!mode && loadEn && !selInRange) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed, table-driven bench for mux_nto1_stream (16 channels) plus a 12-channel
// instance for out-of-range select handling; sel_err is checked when MUX_SEL_ERR_EN is set.
module tb_mux_nto1_stream;

  typedef struct {
    logic        res;
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] inValid;
    logic        outReady;
    logic [15:0] expReady;
    logic [15:0] expOut;
    logic [3:0]  expCh;
    logic        expValid;
  } vec_t;

  logic         clk = 1'b0;
  logic         res;
  logic [255:0] inBus;
  logic [15:0]  inValid;
  logic [15:0]  inReady;
  logic         mode;
  logic [3:0]   sel;
  logic [15:0]  outWord;
  logic [3:0]   outCh;
  logic         outValid;
  logic         outReady;

  logic         res12;
  logic [191:0] inBus12;
  logic [11:0]  inValid12;
  logic [11:0]  inReady12;
  logic         mode12;
  logic [3:0]   sel12;
  logic [15:0]  outWord12;
  logic [3:0]   outCh12;
  logic         outValid12;
  logic         outReady12;

`ifdef MUX_SEL_ERR_EN
  logic selErr;
  logic selErr12;
`endif

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  mux_nto1_stream #(.WIDTH(16), .CHANNELS(16), .SEL_W(4)) dut (
    .clk(clk), .res(res), .in_bus(inBus), .in_valid(inValid), .in_ready(inReady),
    .mode(mode), .sel(sel), .out(outWord), .out_ch(outCh), .out_valid(outValid),
    .out_ready(outReady)
`ifdef MUX_SEL_ERR_EN
    , .sel_err(selErr)
`endif
  );

  mux_nto1_stream #(.WIDTH(16), .CHANNELS(12), .SEL_W(4)) dut12 (
    .clk(clk), .res(res12), .in_bus(inBus12), .in_valid(inValid12), .in_ready(inReady12),
    .mode(mode12), .sel(sel12), .out(outWord12), .out_ch(outCh12), .out_valid(outValid12),
    .out_ready(outReady12)
`ifdef MUX_SEL_ERR_EN
    , .sel_err(selErr12)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic m, input logic [3:0] s,
                              input logic [15:0] v, input logic ordy, input logic [15:0] erdy,
                              input logic [15:0] eo, input logic [3:0] ec, input logic ev);
    vec_t t;
    t.res = r; t.mode = m; t.sel = s; t.inValid = v; t.outReady = ordy;
    t.expReady = erdy; t.expOut = eo; t.expCh = ec; t.expValid = ev;
    return t;
  endfunction

  // Drive one vector mid-cycle, check in_ready before the edge and outputs just after it.
  task automatic runVec(input string tag, input vec_t v);
    @(negedge clk);
    res = v.res; mode = v.mode; sel = v.sel; inValid = v.inValid; outReady = v.outReady;
    #1;
    check({tag, " in_ready"}, 64'(inReady), 64'(v.expReady));
    @(posedge clk);
    #1;
    check({tag, " out"}, 64'(outWord), 64'(v.expOut));
    check({tag, " out_ch"}, 64'(outCh), 64'(v.expCh));
    check({tag, " out_valid"}, 64'(outValid), 64'(v.expValid));
  endtask

  vec_t sweep[$];
  vec_t rr[$];

  initial begin
    for (int k = 0; k < 16; k++) inBus[k*16 +: 16] = 16'(k + 1);
    for (int k = 0; k < 12; k++) inBus12[k*16 +: 16] = 16'(k + 1);

    // Fixed-select sweep 0..15 then wrap to 0.
    for (int s = 0; s < 17; s++) begin
      logic [3:0] sv;
      sv = 4'(s % 16);
      sweep.push_back(mk(1'b0, 1'b0, sv, 16'hFFFF, 1'b1, 16'(1) << sv, 16'(sv) + 16'd1, sv, 1'b1));
    end

    // Round-robin, idle, wrap, reset mid-stream and mode switches; ptr starts at 0.
    rr.push_back(mk(0, 1, 4'd0, 16'h0005, 1, 16'h0001, 16'd1,  4'd0,  1)); // ptr->1
    rr.push_back(mk(0, 1, 4'd0, 16'h0005, 1, 16'h0004, 16'd3,  4'd2,  1)); // ptr->3
    rr.push_back(mk(0, 1, 4'd0, 16'h0005, 1, 16'h0001, 16'd1,  4'd0,  1)); // ptr->1
    rr.push_back(mk(0, 1, 4'd0, 16'h0000, 1, 16'h0000, 16'd1,  4'd0,  0)); // idle, ptr holds 1
    rr.push_back(mk(0, 1, 4'd0, 16'h0005, 1, 16'h0004, 16'd3,  4'd2,  1)); // ptr->3
    rr.push_back(mk(0, 1, 4'd0, 16'h0005, 1, 16'h0001, 16'd1,  4'd0,  1)); // ptr->1
    rr.push_back(mk(1, 1, 4'd0, 16'h0005, 1, 16'h0000, 16'd0,  4'd0,  0)); // reset, ptr->0
    rr.push_back(mk(0, 1, 4'd0, 16'h0005, 1, 16'h0001, 16'd1,  4'd0,  1)); // from ch0, ptr->1
    rr.push_back(mk(0, 1, 4'd0, 16'h8001, 1, 16'h8000, 16'd16, 4'd15, 1)); // ptr wraps ->0
    rr.push_back(mk(0, 1, 4'd0, 16'h8001, 1, 16'h0001, 16'd1,  4'd0,  1)); // ptr->1
    rr.push_back(mk(0, 0, 4'd3, 16'h0001, 1, 16'h0000, 16'd1,  4'd0,  0)); // sel not valid
    rr.push_back(mk(0, 1, 4'd0, 16'h8001, 1, 16'h8000, 16'd16, 4'd15, 1)); // ptr kept at 1

    // Reset: two clocks with all channels valid.
    res = 1'b1; mode = 1'b0; sel = 4'd0; inValid = 16'hFFFF; outReady = 1'b0;
    res12 = 1'b1; mode12 = 1'b0; sel12 = 4'd0; inValid12 = 12'hFFF; outReady12 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("reset in_ready", 64'(inReady), 64'h0);
      @(posedge clk);
      #1;
      check("reset out", 64'(outWord), 64'h0);
      check("reset out_ch", 64'(outCh), 64'h0);
      check("reset out_valid", 64'(outValid), 64'h0);
    end
    res12 = 1'b0;

    foreach (sweep[i]) runVec($sformatf("sweep%0d", i), sweep[i]);

    // Backpressure: stall 5 clocks while sel moves to 5; output must hold channel 0.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      outReady = 1'b0; sel = 4'd5;
      #1;
      check("stall in_ready", 64'(inReady), 64'h0);
      @(posedge clk);
      #1;
      check("stall out", 64'(outWord), 64'd1);
      check("stall out_ch", 64'(outCh), 64'd0);
      check("stall out_valid", 64'(outValid), 64'd1);
    end
    runVec("release", mk(0, 0, 4'd5, 16'hFFFF, 1, 16'h0020, 16'd6, 4'd5, 1));

    foreach (rr[i]) runVec($sformatf("rr%0d", i), rr[i]);

    // 12-channel instance: out-of-range sel gives no grant; sel=11 is the top valid index.
    @(negedge clk);
    sel12 = 4'd13;
    #1;
    check("c12 sel13 in_ready", 64'(inReady12), 64'h0);
    @(posedge clk);
    #1;
    check("c12 sel13 out_valid", 64'(outValid12), 64'd0);
`ifdef MUX_SEL_ERR_EN
    check("c12 sel_err set", 64'(selErr12), 64'd1);
`endif
    @(negedge clk);
    sel12 = 4'd11;
    #1;
    check("c12 sel11 in_ready", 64'(inReady12), 64'h800);
    @(posedge clk);
    #1;
    check("c12 sel11 out", 64'(outWord12), 64'd12);
    check("c12 sel11 out_ch", 64'(outCh12), 64'd11);
    check("c12 sel11 out_valid", 64'(outValid12), 64'd1);
`ifdef MUX_SEL_ERR_EN
    @(negedge clk);
    sel12 = 4'd3;
    @(posedge clk);
    #1;
    check("c12 sel_err sticky", 64'(selErr12), 64'd1);
    @(negedge clk);
    res12 = 1'b1;
    @(posedge clk);
    #1;
    check("c12 sel_err cleared", 64'(selErr12), 64'd0);
    check("c16 sel_err never set", 64'(selErr), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
